// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Purpose  : Per-channel edge detection feeding a round-robin valid/ready
//            event offer with sticky overflow flags.
//            Optional macro EDGE_EVENT_ARBITER_PULSE_ONLY_EN selects one-cycle
//            pulse (0,1,0) detection instead of rising-edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  a,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [CW-1:0] ev_chan,
    output logic [N-1:0]  ovf,
    input  logic          ovf_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [N-1:0]  r_samp;
    logic [N-1:0]  r_hist;
    logic [N-1:0]  w_detect;
    logic [N-1:0]  r_pend;
    logic [N-1:0]  r_ovf;
    logic [N-1:0]  w_load_mask;
    logic [N-1:0]  w_ovf_set;
    logic [N-1:0]  w_rot;
    logic [CW-1:0] r_rr_ptr;
    logic [CW-1:0] r_chan;
    logic [CW-1:0] w_chan_nxt;
    logic [CW-1:0] w_rr_nxt;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_win;
    logic [CW:0]   w_sum;
    logic          w_any;
    logic          w_load;
    logic          w_hs;

    function automatic logic [CW-1:0] inc_mod(input logic [CW-1:0] v);
        return (v == CW'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    // r_samp is the current sample; detection compares it with older samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp <= '0;
            r_hist <= '0;
        end else begin
            r_samp <= a;
            r_hist <= r_samp;
        end
    end

`ifdef EDGE_EVENT_ARBITER_PULSE_ONLY_EN
    logic [N-1:0] r_hist2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist2 <= '0;
        end else begin
            r_hist2 <= r_hist;
        end
    end

    assign w_detect = ~r_hist2 & r_hist & ~r_samp;
`else
    assign w_detect = r_samp & ~r_hist;
`endif

    // On a handshake the scan already starts from the updated pointer
    assign w_hs   = (r_state == ST_OFFER) && ev_ready;
    assign w_base = w_hs ? inc_mod(r_chan) : r_rr_ptr;
    assign w_rot  = N'({r_pend, r_pend} >> w_base);

    always_comb begin
        w_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, w_base} + (CW+1)'(k);
            end
        end
        if (w_sum >= (CW+1)'(N)) begin
            w_sum = w_sum - (CW+1)'(N);
        end
        w_win = w_sum[CW-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_rr_nxt    = r_rr_ptr;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_chan_nxt  = w_win;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ev_ready) begin
                    w_rr_nxt = inc_mod(r_chan);
                    if (w_any) begin
                        w_load     = 1'b1;
                        w_chan_nxt = w_win;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A detect on the channel being loaded becomes a fresh pending event
    assign w_load_mask = w_load ? (N'(1) << w_win) : '0;
    assign w_ovf_set   = w_detect & r_pend & ~w_load_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_chan   <= '0;
            r_rr_ptr <= '0;
            r_pend   <= '0;
            r_ovf    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_chan   <= w_chan_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_pend   <= (r_pend & ~w_load_mask) | w_detect;
            r_ovf    <= (r_ovf & ~{N{ovf_clr}}) | w_ovf_set;
        end
    end

    assign ev_valid = (r_state == ST_OFFER);
    assign ev_chan  = r_chan;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Purpose  : Directed self-checking bench for edge_event_arbiter (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    localparam int c_N  = 4;
    localparam int c_CW = 2;

    logic            clk;
    logic            rst;
    logic [c_N-1:0]  a;
    logic            ev_valid;
    logic            ev_ready;
    logic [c_CW-1:0] ev_chan;
    logic [c_N-1:0]  ovf;
    logic            ovf_clr;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt [c_N] = '{0, 0, 0, 0};
    int s0, s1, s2, s3;

    edge_event_arbiter #(.N(c_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_chan  (ev_chan),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are counted mid-cycle, where inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            hs_cnt[ev_chan] <= hs_cnt[ev_chan] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a   = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        a        = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        #12;
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_chan",  32'(ev_chan),  32'd0);
        check("rst_ovf",   32'(ovf),      32'd0);
        rst = 1'b0;
        tick();

`ifdef EDGE_EVENT_ARBITER_PULSE_ONLY_EN
        // one-cycle pulse 0,1,0 -> one event, 3-clock latency
        do_reset();
        ev_ready = 1'b1;
        s1 = hs_cnt[1];
        a = 4'b0010;
        tick();
        a = 4'b0000;
        check("pl_e0", 32'(ev_valid), 32'd0);
        tick();
        check("pl_e1", 32'(ev_valid), 32'd0);
        tick();
        check("pl_e2", 32'(ev_valid), 32'd0);
        tick();
        check("pl_e3_valid", 32'(ev_valid), 32'd1);
        check("pl_e3_chan",  32'(ev_chan),  32'd1);
        tick();
        check("pl_done", 32'(ev_valid), 32'd0);
        // two-cycle high 0,1,1,0 -> no event
        a = 4'b0010;
        ticks(2);
        a = 4'b0000;
        ticks(6);
        check("pl_wide_none", 32'(ev_valid), 32'd0);
        check("pl_count", hs_cnt[1] - s1, 32'd1);
`else
        // a[2] rises and stays high: one event, 2-clock latency
        do_reset();
        ev_ready = 1'b1;
        s2 = hs_cnt[2];
        a = 4'b0100;
        tick();
        check("lat_e0", 32'(ev_valid), 32'd0);
        tick();
        check("lat_e1", 32'(ev_valid), 32'd0);
        tick();
        check("lat_e2_valid", 32'(ev_valid), 32'd1);
        check("lat_e2_chan",  32'(ev_chan),  32'd2);
        tick();
        check("lat_e3_idle", 32'(ev_valid), 32'd0);
        ticks(4);
        check("single_evt", hs_cnt[2] - s2, 32'd1);
        a = 4'b0000;
        ticks(2);

        // a0, a1, a3 together -> 0, 1, 3 back to back
        do_reset();
        ev_ready = 1'b1;
        a = 4'b1011;
        ticks(3);
        check("rr_first",  32'(ev_chan), 32'd0);
        tick();
        check("rr_second", 32'(ev_chan), 32'd1);
        check("rr_sustain", 32'(ev_valid), 32'd1);
        tick();
        check("rr_third",  32'(ev_chan), 32'd3);
        a = 4'b0000;
        tick();
        check("rr_idle", 32'(ev_valid), 32'd0);
        a = 4'b0011;
        ticks(3);
        check("rr_wrap_ch0", 32'(ev_chan), 32'd0);
        check("rr_wrap_vld", 32'(ev_valid), 32'd1);
        tick();
        check("rr_wrap_ch1", 32'(ev_chan), 32'd1);
        tick();
        check("rr_wrap_idle", 32'(ev_valid), 32'd0);
        a = 4'b0000;
        ticks(2);

        // backpressure: channel 1 held while a[3] rises
        do_reset();
        ev_ready = 1'b0;
        s1 = hs_cnt[1];
        a = 4'b0010;
        ticks(3);
        check("bp_offer", 32'(ev_chan), 32'd1);
        a = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {31'd0, ev_valid} << 4 | 32'(ev_chan), 32'h11);
        end
        ev_ready = 1'b1;
        tick();
        check("bp_next_chan", 32'(ev_chan),  32'd3);
        check("bp_next_vld",  32'(ev_valid), 32'd1);
        tick();
        check("bp_idle", 32'(ev_valid), 32'd0);
        check("bp_ch1_once", hs_cnt[1] - s1, 32'd1);
        check("bp_no_ovf", 32'(ovf), 32'd0);
        a = 4'b0000;
        ticks(2);

        // overflow: second a[2] edge while pending[2] is still set
        do_reset();
        ev_ready = 1'b0;
        s1 = hs_cnt[1];
        s2 = hs_cnt[2];
        a = 4'b0010;
        ticks(3);
        a = 4'b0110;
        tick();
        a = 4'b0010;
        tick();
        a = 4'b0110;
        tick();
        check("ovf_before", 32'(ovf), 32'd0);
        tick();
        check("ovf_set", 32'(ovf), 32'h4);
        ev_ready = 1'b1;
        ticks(5);
        check("ovf_ch2_once", hs_cnt[2] - s2, 32'd1);
        check("ovf_ch1_once", hs_cnt[1] - s1, 32'd1);
        check("ovf_sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        a = 4'b0000;
        ticks(2);

        // asynchronous reset mid-offer with two pending channels
        do_reset();
        ev_ready = 1'b0;
        a = 4'b1011;
        ticks(3);
        check("ar_offer", 32'(ev_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_async_drop", 32'(ev_valid), 32'd0);
        a = 4'b0000;
        ticks(2);
        rst = 1'b0;
        ev_ready = 1'b1;
        s0 = hs_cnt[0]; s1 = hs_cnt[1]; s2 = hs_cnt[2]; s3 = hs_cnt[3];
        ticks(6);
        check("ar_no_events", (hs_cnt[0] - s0) + (hs_cnt[1] - s1) + (hs_cnt[2] - s2) + (hs_cnt[3] - s3), 32'd0);
        check("ar_idle", 32'(ev_valid), 32'd0);

        // channel held high across reset release -> one event
        rst = 1'b1;
        a = 4'b0010;
        tick();
        rst = 1'b0;
        s1 = hs_cnt[1];
        ticks(8);
        check("hold_rst_evt", hs_cnt[1] - s1, 32'd1);
        a = 4'b0000;
        ticks(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
